// File: rtl/tmr_scrub_register_pkg.sv
// tmr_scrub_register_pkg: shared defaults, error-flag indices and the bitwise majority vote.
package tmr_scrub_register_pkg;
    localparam int DEF_WIDTH        = 8;
    localparam int DEF_SCRUB_PERIOD = 4;
    localparam int DEF_CNT_W        = 4;
    localparam int MAX_W            = 64;
    localparam int ERR_A = 0;
    localparam int ERR_B = 1;
    localparam int ERR_C = 2;
    typedef enum logic {RUN, SCRUB} state_t;
    function automatic logic [MAX_W-1:0] maj3(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                              input logic [MAX_W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/tmr_scrub_register_maj3_vote.sv
// maj3_vote: WIDTH-bit combinational bitwise majority voter.
module maj3_vote
    import tmr_scrub_register_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);
    assign y = WIDTH'(maj3(MAX_W'(a), MAX_W'(b), MAX_W'(c)));
endmodule

// File: rtl/tmr_scrub_register.sv
// tmr_scrub_register: triplicated register with voted load, periodic scrubbing and SEU error counting.
module tmr_scrub_register
    import tmr_scrub_register_pkg::*;
#(
    parameter int               WIDTH        = DEF_WIDTH,
    parameter int               SCRUB_PERIOD = DEF_SCRUB_PERIOD,
    parameter int               CNT_W        = DEF_CNT_W,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [WIDTH-1:0] inC,
    input  logic             load,
    input  logic             clear_err,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] outA,
    output logic [WIDTH-1:0] outB,
    output logic [WIDTH-1:0] outC,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky,
    output logic [2:0]       err_copy,
    output logic             in_err
);
    localparam int             TW   = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
    localparam logic [TW-1:0]  LAST = TW'(SCRUB_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] copy_a, copy_b, copy_c, in_v, v;
    logic [2:0]       diff;
    logic             in_dis, scrub_hit;
    state_t           st;
    maj3_vote #(.WIDTH(WIDTH)) u_in_vote (.a(inA), .b(inB), .c(inC), .y(in_v));
    maj3_vote #(.WIDTH(WIDTH)) u_st_vote (.a(copy_a), .b(copy_b), .c(copy_c), .y(v));
    always_comb begin
        st           = (timer == LAST) ? SCRUB : RUN;
        diff         = '0;
        diff[ERR_A]  = copy_a != v;
        diff[ERR_B]  = copy_b != v;
        diff[ERR_C]  = copy_c != v;
        in_dis       = (inA != inB) || (inB != inC);
        // a load on a scrub cycle wins and suppresses the comparison entirely
        scrub_hit    = (st == SCRUB) && !load && (|diff);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer      <= '0;
            copy_a     <= RESET_VAL;
            copy_b     <= RESET_VAL;
            copy_c     <= RESET_VAL;
            err_cnt    <= '0;
            err_sticky <= 1'b0;
            err_copy   <= '0;
            in_err     <= 1'b0;
        end else begin
            timer <= (timer == LAST) ? '0 : timer + 1'b1;
            if (load) begin
                copy_a <= in_v;
                copy_b <= in_v;
                copy_c <= in_v;
            end else if (st == SCRUB) begin
                copy_a <= v;
                copy_b <= v;
                copy_c <= v;
            end
            if (load && in_dis) in_err <= 1'b1;
            else if (clear_err) in_err <= 1'b0;
            if (scrub_hit) begin
                err_sticky <= 1'b1;
                err_copy   <= clear_err ? diff : (err_copy | diff);
                err_cnt    <= clear_err ? CNT_W'(1) : (err_cnt == CNT_MAX) ? err_cnt : err_cnt + 1'b1;
            end else if (clear_err) begin
                err_sticky <= 1'b0;
                err_copy   <= '0;
                err_cnt    <= '0;
            end
        end
    end
    assign out  = v;
    assign outA = copy_a;
    assign outB = copy_b;
    assign outC = copy_c;
endmodule

// File: tb/tb_tmr_scrub_register.sv
// tb_tmr_scrub_register: directed checks of voting, scrubbing, error counting and reset.
module tb_tmr_scrub_register;
    logic       clk, rst, load, clear_err;
    logic [7:0] inA, inB, inC, out, outA, outB, outC;
    logic [3:0] err_cnt;
    logic       err_sticky, in_err;
    logic [2:0] err_copy;
    int         compared = 0;
    int         mismatched = 0;

    tmr_scrub_register dut (
        .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC), .load(load), .clear_err(clear_err),
        .out(out), .outA(outA), .outB(outB), .outC(outC), .err_cnt(err_cnt),
        .err_sticky(err_sticky), .err_copy(err_copy), .in_err(in_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_copies(input string tag, input logic [7:0] exp);
        chk({tag, ".out"}, 64'(out), 64'(exp));
        chk({tag, ".outA"}, 64'(outA), 64'(exp));
        chk({tag, ".outB"}, 64'(outB), 64'(exp));
        chk({tag, ".outC"}, 64'(outC), 64'(exp));
    endtask

    task automatic chk_err(input string tag, input logic [3:0] cnt, input logic sticky,
                           input logic [2:0] cp, input logic ie);
        chk({tag, ".err_cnt"}, 64'(err_cnt), 64'(cnt));
        chk({tag, ".err_sticky"}, 64'(err_sticky), 64'(sticky));
        chk({tag, ".err_copy"}, 64'(err_copy), 64'(cp));
        chk({tag, ".in_err"}, 64'(in_err), 64'(ie));
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; clear_err = 1'b0; inA = '0; inB = '0; inC = '0;
        cyc(1);
        chk_copies("reset", 8'h00);
        chk_err("reset", 4'd0, 1'b0, 3'b000, 1'b0);
        rst = 1'b0;
        // edges 1..4, edge 4 is the first scrub; nothing to correct
        cyc(4);
        chk_copies("idle_scrub", 8'h00);
        chk_err("idle_scrub", 4'd0, 1'b0, 3'b000, 1'b0);
        // edge 5: agreeing load
        load = 1'b1; inA = 8'hA5; inB = 8'hA5; inC = 8'hA5;
        cyc(1);
        load = 1'b0;
        chk_copies("load_eq", 8'hA5);
        chk("load_eq.in_err", 64'(in_err), 64'd0);
        // edge 6: disagreeing load
        load = 1'b1; inC = 8'h5A;
        cyc(1);
        load = 1'b0;
        chk_copies("load_ne", 8'hA5);
        chk_err("load_ne", 4'd0, 1'b0, 3'b000, 1'b1);
        // edge 7: agreeing load with clear_err drops in_err
        load = 1'b1; clear_err = 1'b1; inA = 8'h3C; inB = 8'h3C; inC = 8'h3C;
        cyc(1);
        load = 1'b0; clear_err = 1'b0;
        chk_copies("load_3c", 8'h3C);
        chk("load_3c.in_err", 64'(in_err), 64'd0);
        // upset copy B, corrected at scrub edge 8
        force dut.copy_b = 8'h3D;
        #1 release dut.copy_b;
        chk("upset_b.out", 64'(out), 64'h3C);
        chk("upset_b.outB", 64'(outB), 64'h3D);
        cyc(1);
        chk_copies("scrub_b", 8'h3C);
        chk_err("scrub_b", 4'd1, 1'b1, 3'b010, 1'b0);
        // 20 more corrected scrubs on copy A: count saturates at 15
        for (int k = 0; k < 20; k++) begin
            force dut.copy_a = 8'hBC;
            #1 release dut.copy_a;
            cyc(4);
            chk($sformatf("sat%0d.err_cnt", k), 64'(err_cnt), (k + 2 > 15) ? 64'd15 : 64'(k + 2));
            chk($sformatf("sat%0d.outA", k), 64'(outA), 64'h3C);
        end
        chk_err("sat_end", 4'd15, 1'b1, 3'b011, 1'b0);
        // clear_err coinciding with a copy C error at scrub edge 92
        force dut.copy_c = 8'h3D;
        #1 release dut.copy_c;
        cyc(3);
        clear_err = 1'b1;
        cyc(1);
        clear_err = 1'b0;
        chk_copies("clr_err", 8'h3C);
        chk_err("clr_err", 4'd1, 1'b1, 3'b100, 1'b0);
        // load on scrub edge 96 while copy A is upset: scrub suppressed
        force dut.copy_a = 8'h00;
        #1 release dut.copy_a;
        cyc(3);
        load = 1'b1; inA = 8'h77; inB = 8'h77; inC = 8'h77;
        cyc(1);
        load = 1'b0;
        chk_copies("load_scrub", 8'h77);
        chk_err("load_scrub", 4'd1, 1'b1, 3'b100, 1'b0);
        // timer unaffected by the load: next scrub at edge 100
        force dut.copy_b = 8'h76;
        #1 release dut.copy_b;
        cyc(3);
        chk("pre_scrub.outB", 64'(outB), 64'h76);
        chk("pre_scrub.err_cnt", 64'(err_cnt), 64'd1);
        cyc(1);
        chk_copies("post_scrub", 8'h77);
        chk_err("post_scrub", 4'd2, 1'b1, 3'b110, 1'b0);
        // asynchronous reset with a load pending
        load = 1'b1; inA = 8'h11; inB = 8'h11; inC = 8'h11;
        rst = 1'b1;
        #1;
        chk_copies("async_rst", 8'h00);
        chk_err("async_rst", 4'd0, 1'b0, 3'b000, 1'b0);
        cyc(1);
        chk_copies("rst_hold", 8'h00);
        rst = 1'b0; load = 1'b0;
        // timer restarted: first scrub again on the 4th edge
        force dut.copy_c = 8'h01;
        #1 release dut.copy_c;
        cyc(3);
        chk("rst_timer.outC", 64'(outC), 64'h01);
        chk("rst_timer.err_cnt", 64'(err_cnt), 64'd0);
        cyc(1);
        chk_copies("rst_scrub", 8'h00);
        chk_err("rst_scrub", 4'd1, 1'b1, 3'b100, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
